// File: rtl/rom_stream_pkg.sv
// Shared types and constants for the ROM stream reader: FSM encoding,
// output FIFO depth and the read-pipeline in-flight limit.
package rom_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH   = 4;
    localparam int PTR_W        = 2;
    localparam int OCC_W        = 3;
    localparam int INFLIGHT_MAX = 2;

    // Number of reads currently travelling through the ROM pipeline.
    function automatic logic [OCC_W-1:0] flight_count(input logic [INFLIGHT_MAX-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i < INFLIGHT_MAX; i++) begin
            n = n + OCC_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rom_stream_fifo.sv
// Four-entry output FIFO for ROM words; head word is visible combinationally
// so it can drive the stream output directly.
module rom_stream_fifo
    import rom_stream_pkg::*;
#(
    parameter int DW = 5
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [DW-1:0]    i_din,
    input  logic             i_pop,
    output logic [DW-1:0]    o_dout,
    output logic             o_empty,
    output logic [OCC_W-1:0] o_occ
);

    logic [DW-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push && (r_occ != OCC_W'(FIFO_DEPTH));
    assign w_pop  = i_pop && (r_occ != '0);

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    r_mem[gi] <= '0;
                end else if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
                    r_mem[gi] <= i_din;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = (r_occ == '0);
    assign o_occ   = r_occ;

endmodule

// File: rtl/rom_stream_reader.sv
// Burst reader for a one-cycle-latency ROM presenting words on a valid/ready
// stream. Define ROM_STREAM_LOOP_EN to add i_stop and repeat bursts until stopped.
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int AW    = 10,
    parameter int DW    = 5
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [AW-1:0] i_base,
    input  logic [AW-1:0] i_count,
`ifdef ROM_STREAM_LOOP_EN
    input  logic          i_stop,
`endif
    output logic [AW-1:0] o_rom_addr,
    input  logic [DW-1:0] i_rom_d,
    output logic [DW-1:0] o_out_d,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [AW-1:0]           r_addr;
    logic [AW-1:0]           w_addr_next;
    logic [AW-1:0]           r_remain;
    logic [AW-1:0]           w_remain_next;
    logic [INFLIGHT_MAX-1:0] r_flight;
    logic                    r_busy;
    logic                    w_busy_next;
    logic                    r_done;
    logic                    w_done_next;
    logic                    r_err;
    logic                    w_err_next;
    logic                    w_issue;
    logic                    w_pop;
    logic                    w_empty;
    logic [OCC_W-1:0]        w_occ;
    logic                    w_room;
    logic                    w_drained;
    logic [AW-1:0]           w_addr_inc;
`ifdef ROM_STREAM_LOOP_EN
    logic [AW-1:0]           r_base;
    logic [AW-1:0]           r_count;
`endif

    rom_stream_fifo #(.DW(DW)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (r_flight[INFLIGHT_MAX-1]),
        .i_din   (i_rom_d),
        .i_pop   (w_pop),
        .o_dout  (o_out_d),
        .o_empty (w_empty),
        .o_occ   (w_occ)
    );

    assign o_out_valid = !w_empty;
    assign w_pop       = o_out_valid && i_out_ready;
    assign w_addr_inc  = (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);
    // Every in-flight read will land in the FIFO, so reserve a slot for each.
    assign w_room      = ({1'b0, w_occ} + {1'b0, flight_count(r_flight)}) < 4'(FIFO_DEPTH);
    assign w_drained   = (r_flight == '0) &&
                         ((w_occ == '0) || ((w_occ == OCC_W'(1)) && w_pop));

    always_comb begin
        w_state_next  = r_state;
        w_addr_next   = r_addr;
        w_remain_next = r_remain;
        w_busy_next   = r_busy;
        w_done_next   = 1'b0;
        w_err_next    = 1'b0;
        w_issue       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_base >= AW'(DEPTH)) begin
                        w_err_next = 1'b1;
                    end else if (i_count == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_issue       = 1'b1;
                        w_addr_next   = i_base;
                        w_remain_next = i_count - AW'(1);
                        w_busy_next   = 1'b1;
`ifdef ROM_STREAM_LOOP_EN
                        w_state_next  = ST_RUN;
`else
                        w_state_next  = (i_count == AW'(1)) ? ST_DRAIN : ST_RUN;
`endif
                    end
                end
            end
            ST_RUN: begin
`ifdef ROM_STREAM_LOOP_EN
                if (i_stop) begin
                    w_state_next = ST_DRAIN;
                end else if (w_room) begin
                    w_issue = 1'b1;
                    if (r_remain == '0) begin
                        w_addr_next   = r_base;
                        w_remain_next = r_count - AW'(1);
                    end else begin
                        w_addr_next   = w_addr_inc;
                        w_remain_next = r_remain - AW'(1);
                    end
                end
`else
                if (w_room) begin
                    w_issue       = 1'b1;
                    w_addr_next   = w_addr_inc;
                    w_remain_next = r_remain - AW'(1);
                    if (r_remain == AW'(1)) begin
                        w_state_next = ST_DRAIN;
                    end
                end
`endif
            end
            ST_DRAIN: begin
                if (w_drained) begin
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_flight <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_addr   <= w_addr_next;
            r_remain <= w_remain_next;
            r_flight <= {r_flight[INFLIGHT_MAX-2:0], w_issue};
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
            r_err    <= w_err_next;
        end
    end

`ifdef ROM_STREAM_LOOP_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_base  <= '0;
            r_count <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_base  <= i_base;
            r_count <= i_count;
        end
    end
`endif

    assign o_rom_addr = r_addr;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: ROM holds rom[i]=i; a word-order model checks the
// stream every cycle while directed commands pin latency, wrap, stalls and errors.
module tb_rom_stream_reader;

    localparam int DEPTH = 10;
    localparam int AW    = 10;
    localparam int DW    = 5;
`ifdef ROM_STREAM_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW-1:0] count = '0;
    logic          stop = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_d = '0;
    logic [DW-1:0] out_d;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    rom_stream_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_base      (base),
        .i_count     (count),
`ifdef ROM_STREAM_LOOP_EN
        .i_stop      (stop),
`endif
        .o_rom_addr  (rom_addr),
        .i_rom_d     (rom_d),
        .o_out_d     (out_d),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with rom[i] = i.
    always @(posedge clk) begin
        rom_d <= (rom_addr < AW'(DEPTH)) ? rom_addr[DW-1:0] : '0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a burst is (base, count); word k must be (base + k mod count) mod DEPTH.
    bit            m_busy = 1'b0;
    bit            m_loop = 1'b0;
    int            m_idx = 0;
    int            m_base = 0;
    int            m_count = 0;
    int            n_xfer = 0;
    bit            e_done = 1'b0;
    bit            e_err = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    bit            was_busy;
    int            exp_w;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_loop = 1'b0;
            e_done = 1'b0;
            e_err = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (m_loop) begin
                if (done) begin
                    m_busy = 1'b0;
                    m_loop = 1'b0;
                end
            end else begin
                chk("done", 32'(done), 32'(e_done));
            end
            chk("busy", 32'(busy), 32'(m_busy));
            chk("err", 32'(err), 32'(e_err));
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_d), 32'(prev_d));
            end
            if (!m_busy) begin
                chk("valid_idle", 32'(out_valid), 0);
            end
            was_busy = m_busy;
            e_done = 1'b0;
            e_err = 1'b0;
            if (out_valid && out_ready && m_busy) begin
                exp_w = (m_base + (m_idx % m_count)) % DEPTH;
                chk("data", 32'(out_d), 32'(exp_w));
                m_idx++;
                n_xfer++;
                if (!m_loop && (m_idx == m_count)) begin
                    e_done = 1'b1;
                    m_busy = 1'b0;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_d;
            if (start && !was_busy) begin
                if (int'(base) >= DEPTH) begin
                    e_err = 1'b1;
                end else if (count == '0) begin
                    e_done = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    m_idx = 0;
                    m_base = int'(base);
                    m_count = int'(count);
                    m_loop = LOOP_EN;
                end
            end
        end
    end

    // Called at posedge+1; returns at the accepting edge + 1.
    task automatic cmd(input int b, input int c);
        start = 1'b1;
        base = AW'(b);
        count = AW'(c);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step(1);
            if (!busy && !out_valid && !done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", 32'(ok), 1);
    endtask

    task automatic wait_done(input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step(1);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_timeout", 32'(ok), 1);
    endtask

    initial begin
        int n0;
        bit ok;
        #1;
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_out_d", 32'(out_d), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        step(2);
        rst = 1'b0;
        step(1);

`ifdef ROM_STREAM_LOOP_EN
        n0 = n_xfer;
        cmd(0, 3);
        step(15);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        wait_done(40);
        chk("loop_words", 32'((n_xfer - n0) >= 6), 1);
        wait_idle(10);
`else
        // Full burst, first-word latency and done timing
        n0 = n_xfer;
        cmd(0, 10);
        chk("e0_addr", 32'(rom_addr), 0);
        chk("e0_busy", 32'(busy), 1);
        chk("e0_valid", 32'(out_valid), 0);
        step(1);
        chk("e1_addr", 32'(rom_addr), 1);
        chk("e1_valid", 32'(out_valid), 0);
        step(1);
        chk("e2_valid", 32'(out_valid), 1);
        chk("e2_data", 32'(out_d), 0);
        step(9);
        chk("e11_data", 32'(out_d), 9);
        step(1);
        chk("e12_done", 32'(done), 1);
        chk("e12_busy", 32'(busy), 0);
        chk("e12_valid", 32'(out_valid), 0);
        step(1);
        chk("e13_done", 32'(done), 0);
        chk("xfers_full", 32'(n_xfer - n0), 10);

        // Address wrap
        n0 = n_xfer;
        cmd(8, 5);
        wait_idle(40);
        chk("xfers_wrap", 32'(n_xfer - n0), 5);

        // Backpressure: stall after word 0, then toggle ready
        n0 = n_xfer;
        cmd(0, 10);
        step(3);
        out_ready = 1'b0;
        step(1);
        chk("stall_addr_a", 32'(rom_addr), 4);
        step(5);
        chk("stall_addr_b", 32'(rom_addr), 4);
        chk("stall_head", 32'(out_d), 1);
        for (int i = 0; i < 20; i++) begin
            out_ready = (i % 2 == 0);
            step(1);
        end
        out_ready = 1'b1;
        wait_idle(40);
        chk("xfers_bp", 32'(n_xfer - n0), 10);

        // Empty command
        cmd(3, 0);
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 0);
        step(1);
        chk("zero_done_off", 32'(done), 0);
        chk("zero_valid", 32'(out_valid), 0);

        // Illegal bases, including the first address past the end
        cmd(12, 3);
        chk("err12", 32'(err), 1);
        chk("err12_busy", 32'(busy), 0);
        step(1);
        chk("err12_off", 32'(err), 0);
        cmd(10, 1);
        chk("err10", 32'(err), 1);
        step(2);

        // Last legal address, single word
        n0 = n_xfer;
        cmd(9, 1);
        wait_idle(20);
        chk("xfers_last", 32'(n_xfer - n0), 1);

        // Start while busy is ignored
        n0 = n_xfer;
        cmd(0, 10);
        step(2);
        cmd(5, 3);
        wait_idle(40);
        chk("xfers_ignored", 32'(n_xfer - n0), 10);

        // Back-to-back bursts: new start in the done cycle
        n0 = n_xfer;
        cmd(2, 2);
        wait_done(20);
        cmd(4, 3);
        chk("b2b_busy", 32'(busy), 1);
        wait_idle(30);
        chk("xfers_b2b", 32'(n_xfer - n0), 5);

        // Reset after 3 transfers
        n0 = n_xfer;
        cmd(0, 10);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if ((n_xfer - n0) >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_wait", 32'(ok), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_addr", 32'(rom_addr), 0);
        step(2);
        rst = 1'b0;
        step(1);
        n0 = n_xfer;
        cmd(0, 4);
        wait_idle(30);
        chk("xfers_after_rst", 32'(n_xfer - n0), 4);
`endif

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Read-side sequencer for the synchronous lookup ROM. It accepts a burst command (base address, word count), drives the ROM address port, absorbs the ROM's one-cycle registered read latency, and presents the words in order on a valid/ready output stream with full backpressure. It sits between the ROM and downstream consumers such as display or pattern logic, so those blocks need not track ROM latency.

## Interface
- DEPTH, 10: number of populated ROM words; legal addresses are 0..DEPTH-1.
- AW, 10: ROM address width.
- DW, 5: ROM data width.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base  in  AW  first address of the burst.
- count  in  AW  number of words to stream; 0 is legal.
- rom_addr  out  AW  to ROM addr; registered.
- rom_d  in  DW  from ROM d; valid one edge after rom_addr is presented.
- out_d  out  DW  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  downstream ready.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  one-cycle pulse on an illegal command.

## Operation
- Reset values: rom_addr=0, out_d=0, out_valid=0, busy=0, done=0, err=0, FIFO empty, state IDLE, in-flight count 0.
- States: IDLE, RUN, DRAIN.
- IDLE transitions when start=1:
  - If base>=DEPTH: pulse err; stay IDLE; issue no reads.
  - Else if count=0: pulse done on the next cycle; busy stays 0.
  - Else: go to RUN, busy=1, and load the address and remaining-count registers.
- RUN: issue one read per cycle while `FIFO occupancy + reads in flight < 4`.
  - The address increments after each read and wraps from DEPTH-1 to 0.
  - Go to DRAIN once count reads have been issued.
- DRAIN: wait until the in-flight count is 0 and the FIFO is empty. Then pulse done, clear busy and return to IDLE.
- At most 2 reads are in flight: address presented, and ROM output pending capture. The 4-entry FIFO therefore never overflows.
- Output handshake: a word transfers on a cycle with out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_d holds stable.
  - out_valid never drops without a transfer.
- Words are never dropped, duplicated or reordered.
- start outside IDLE is ignored. Command inputs are sampled only on the accepting edge.
- Reset mid-burst clears all state asynchronously. Words already buffered are discarded.

## Timing
- The start-sampling edge E0 presents rom_addr=base.
- At E1 the ROM registers the data. At E2 the FIFO captures it, and out_valid=1 from E2 onward.
- First-word latency is therefore 2 edges after E0.
- With out_ready held at 1, throughput is one word per cycle with no bubbles.
- done pulses in the cycle after the edge that transfers the last word. busy falls on the same edge.
- A new start is accepted in the cycle that done is high. This gives back-to-back bursts with a one-cycle gap.

## Configuration
- ROM_STREAM_LOOP_EN:
  - Defined: adds input port stop (1 bit). In RUN, after count reads the address reloads to base and streaming repeats indefinitely. When stop is sampled high, issuing ceases, the block enters DRAIN, and done pulses after the last issued word transfers.
  - Undefined: no stop port; single pass as described above.

## Structure
- Package rom_stream_pkg:
  - state encoding IDLE/RUN/DRAIN;
  - FIFO_DEPTH=4;
  - in-flight limit 2.
- Sub-module rom_stream_fifo: a 4-entry, DW-wide synchronous FIFO with push/pop/occupancy. The top level holds the FSM, address/count registers and the in-flight tracker.

## Test plan
- ROM preloaded so rom[i]=i:
  - base=0, count=10, out_ready=1 -> out_d 0..9 on consecutive cycles; first out_valid at E2; done one cycle after word 9.
  - base=8, count=5 -> out_d 8,9,0,1,2 (wrap); exactly 5 transfers.
- Backpressure: base=0, count=10, out_ready low for 6 cycles mid-burst and then toggling 1,0 -> out_d stable while stalled; rom_addr stops advancing once 4 words are held; full 0..9 sequence with no loss or duplicate.
- Illegal and empty commands: count=0 -> done pulse next cycle, no out_valid. base=12 -> err pulse, busy=0. start while busy -> ignored.
- Reset during a burst after 3 transfers -> out_valid, busy and done go to 0 immediately. After release, base=0, count=4 streams 0,1,2,3.
- ROM_STREAM_LOOP_EN: base=0, count=3 -> 0,1,2,0,1,2,…; assert stop -> issued words drain in order, then done pulses.
